// File: rtl/text_capture.sv
// text_capture: sniffs printable characters the CPU writes to the display
// port and keeps them in an on-chip buffer that the host can read back
// over the ioctl upload interface as a plain text file.
module text_capture #(
    parameter int BUF_AW   = 12,
    parameter bit WRAP     = 1'b0,
    parameter bit CR_TO_LF = 1'b1
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cs,
    input  logic              w_en,
    input  logic              address,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              capture_en,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [BUF_AW-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [BUF_AW:0]   capture_len,
    output logic              overflow,
    output logic              busy
);

    localparam int DEPTH = 2 ** BUF_AW;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;
    localparam logic [1:0] S_UPLOAD  = 2'd3;

    localparam logic [BUF_AW:0]   LEN_FULL = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW:0]   LEN_ONE  = {{BUF_AW{1'b0}}, 1'b1};
    localparam logic [BUF_AW-1:0] PTR_ONE  = {{(BUF_AW-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [BUF_AW-1:0] r_wr_ptr;
    logic [BUF_AW:0]   r_len;
    logic              r_ovf;
    logic              r_cen_q;
    logic [7:0]        r_ioctl_dout;
    logic [7:0]        r_mem [DEPTH];

    logic [7:0]        w_char7;
    logic [7:0]        w_char;
    logic              w_printable;
    logic              w_keep;
    logic              w_rise;
    logic              w_store;
    logic [BUF_AW-1:0] w_store_idx;
    logic [BUF_AW-1:0] w_rd_idx;
    logic              w_in_range;

    // Character cleanup and filter: 7-bit ASCII, optional CR->LF, printable + CR/LF only
    always_comb begin
        w_char7 = din & 8'h7F;
        w_char  = (CR_TO_LF && (w_char7 == 8'h0D)) ? 8'h0A : w_char7;
        w_printable = !((w_char < 8'h20) && (w_char != 8'h0A) && (w_char != 8'h0D))
                      && (w_char != 8'h7F);
        w_keep  = cs & w_en & enable & ~address & w_printable;
        w_rise  = capture_en & ~r_cen_q;
    end

    // RAM write-port control; a start-of-capture write lands at index 0 after the clear
    always_comb begin
        w_store     = 1'b0;
        w_store_idx = r_wr_ptr;
        if (r_state == S_IDLE) begin
            if (w_rise) begin
                w_store     = w_keep;
                w_store_idx = '0;
            end
        end else if (r_state == S_CAPTURE) begin
            w_store = w_keep & ~ioctl_upload & capture_en;
        end
    end

    // Capture FSM, write pointer, length and overflow tracking
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_ovf    <= 1'b0;
            r_cen_q  <= 1'b0;
        end else begin
            r_cen_q <= capture_en;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_CAPTURE;
                        r_ovf   <= 1'b0;
                        if (w_keep) begin
                            r_wr_ptr <= PTR_ONE;
                            r_len    <= LEN_ONE;
                        end else begin
                            r_wr_ptr <= '0;
                            r_len    <= '0;
                        end
                    end else if (ioctl_upload) begin
                        r_state <= S_UPLOAD;
                    end
                end
                S_CAPTURE: begin
                    if (ioctl_upload) begin
                        r_state <= S_UPLOAD;
                    end else if (!capture_en) begin
                        r_state <= S_IDLE;
                    end else if (w_keep) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (r_len != LEN_FULL) begin
                            r_len <= r_len + LEN_ONE;
                        end else if (WRAP) begin
                            r_ovf <= 1'b1;
                        end
                        if (!WRAP && (r_wr_ptr == '1)) begin
                            r_state <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (ioctl_upload) begin
                        r_state <= S_UPLOAD;
                    end else if (!capture_en) begin
                        r_state <= S_IDLE;
                    end else if (w_keep) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: begin
                    if (!ioctl_upload) begin
                        if (capture_en && (r_len != LEN_FULL)) begin
                            r_state <= S_CAPTURE;
                        end else if (capture_en) begin
                            r_state <= S_FULL;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Buffer write port (CPU side)
    always_ff @(posedge clk25) begin
        if (w_store) begin
            r_mem[w_store_idx] <= w_char;
        end
    end

    // Host read index: once a circular buffer has filled, the oldest byte sits at wr_ptr
    always_comb begin
        w_rd_idx   = (WRAP && (r_len == LEN_FULL)) ? (r_wr_ptr + ioctl_addr) : ioctl_addr;
        w_in_range = ({1'b0, ioctl_addr} < r_len);
    end

    // Buffer read port (host side), registered, holds when no read strobe
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_ioctl_dout <= 8'h00;
        end else if (ioctl_rd) begin
            r_ioctl_dout <= w_in_range ? r_mem[w_rd_idx] : 8'h00;
        end
    end

    // Status byte and output mapping
    always_comb begin
        dout        = address ? {r_state == S_CAPTURE, r_ovf, r_state == S_FULL,
                                 r_state == S_UPLOAD, 4'b0000} : 8'h00;
        busy        = (r_state == S_UPLOAD);
        ioctl_dout  = r_ioctl_dout;
        capture_len = r_len;
        overflow    = r_ovf;
    end

endmodule

// File: tb/tb_text_capture.sv
// Self-checking bench for text_capture: three instances (large linear,
// small linear, small circular without CR->LF) share one stimulus stream
// and are compared every cycle against a list-based reference model.
module tb_text_capture;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cs;
    logic        w_en;
    logic        address;
    logic [7:0]  din;
    logic        cap_en;
    logic        upload;
    logic        rd;
    logic [11:0] addr;

    logic [7:0]  dout0, dout1, dout2;
    logic [7:0]  rdd0, rdd1, rdd2;
    logic [12:0] len0;
    logic [4:0]  len1, len2;
    logic        ovf0, ovf1, ovf2;
    logic        busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    text_capture #(.BUF_AW(12), .WRAP(1'b0), .CR_TO_LF(1'b1)) u_big (
        .clk25(clk), .rst_n(rst_n), .enable(enable), .cs(cs), .w_en(w_en),
        .address(address), .din(din), .dout(dout0), .capture_en(cap_en),
        .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr),
        .ioctl_dout(rdd0), .capture_len(len0), .overflow(ovf0), .busy(busy0)
    );

    text_capture #(.BUF_AW(4), .WRAP(1'b0), .CR_TO_LF(1'b1)) u_lin (
        .clk25(clk), .rst_n(rst_n), .enable(enable), .cs(cs), .w_en(w_en),
        .address(address), .din(din), .dout(dout1), .capture_en(cap_en),
        .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr[3:0]),
        .ioctl_dout(rdd1), .capture_len(len1), .overflow(ovf1), .busy(busy1)
    );

    text_capture #(.BUF_AW(4), .WRAP(1'b1), .CR_TO_LF(1'b0)) u_circ (
        .clk25(clk), .rst_n(rst_n), .enable(enable), .cs(cs), .w_en(w_en),
        .address(address), .din(din), .dout(dout2), .capture_en(cap_en),
        .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr[3:0]),
        .ioctl_dout(rdd2), .capture_len(len2), .overflow(ovf2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The captured text is kept as a plain list: oldest byte at index 0.
    localparam int M_IDLE = 0;
    localparam int M_CAP  = 1;
    localparam int M_FULL = 2;
    localparam int M_UP   = 3;

    int unsigned m_depth [3] = '{4096, 16, 16};
    bit          m_wrap  [3] = '{1'b0, 1'b0, 1'b1};
    bit          m_crlf  [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  m_text  [3][4096];
    int unsigned m_size  [3];
    int          m_mode  [3];
    bit          m_ovf   [3];
    logic [7:0]  m_rd    [3];
    bit          m_cen_prev;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_size[k] = 0;
            m_mode[k] = M_IDLE;
            m_ovf[k]  = 1'b0;
            m_rd[k]   = 8'h00;
        end
        m_cen_prev = 1'b0;
    endtask

    task automatic model_append(input int k, input logic [7:0] c);
        if (m_size[k] == m_depth[k]) begin
            for (int unsigned i = 0; i + 1 < m_depth[k]; i++) m_text[k][i] = m_text[k][i+1];
            m_text[k][m_depth[k]-1] = c;
            m_ovf[k] = 1'b1;
        end else begin
            m_text[k][m_size[k]] = c;
            m_size[k]++;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0]  c;
        bit          keep;
        bit          rise;
        int unsigned a;
        c = din & 8'h7F;
        if (m_crlf[k] && c == 8'h0D) c = 8'h0A;
        keep = cs && w_en && enable && !address && (c != 8'h7F) &&
               !(c < 8'h20 && c != 8'h0A && c != 8'h0D);
        rise = cap_en && !m_cen_prev;
        if (rd) begin
            a = int'(addr) % m_depth[k];
            m_rd[k] = (a < m_size[k]) ? m_text[k][a] : 8'h00;
        end
        case (m_mode[k])
            M_IDLE: begin
                if (rise) begin
                    m_size[k] = 0;
                    m_ovf[k]  = 1'b0;
                    m_mode[k] = M_CAP;
                    if (keep) model_append(k, c);
                end else if (upload) begin
                    m_mode[k] = M_UP;
                end
            end
            M_CAP: begin
                if (upload) m_mode[k] = M_UP;
                else if (!cap_en) m_mode[k] = M_IDLE;
                else if (keep) begin
                    model_append(k, c);
                    if (!m_wrap[k] && m_size[k] == m_depth[k]) m_mode[k] = M_FULL;
                end
            end
            M_FULL: begin
                if (upload) m_mode[k] = M_UP;
                else if (!cap_en) m_mode[k] = M_IDLE;
                else if (keep) m_ovf[k] = 1'b1;
            end
            default: begin
                if (!upload) begin
                    if (cap_en && m_size[k] < m_depth[k]) m_mode[k] = M_CAP;
                    else if (cap_en) m_mode[k] = M_FULL;
                    else m_mode[k] = M_IDLE;
                end
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic [12:0] len, input logic ovf,
                              input logic bsy, input logic [7:0] rdd, input logic [7:0] st);
        logic [7:0] exp_st;
        exp_st = address ? {m_mode[k] == M_CAP, m_ovf[k], m_mode[k] == M_FULL,
                            m_mode[k] == M_UP, 4'b0000} : 8'h00;
        check_eq($sformatf("i%0d.len", k), 32'(len), 32'(m_size[k]));
        check_eq($sformatf("i%0d.ovf", k), 32'(ovf), 32'(m_ovf[k]));
        check_eq($sformatf("i%0d.busy", k), 32'(bsy), 32'(m_mode[k] == M_UP));
        check_eq($sformatf("i%0d.rdata", k), 32'(rdd), 32'(m_rd[k]));
        check_eq($sformatf("i%0d.status", k), 32'(st), 32'(exp_st));
    endtask

    task automatic check_all();
        check_inst(0, len0, ovf0, busy0, rdd0, dout0);
        check_inst(1, 13'(len1), ovf1, busy1, rdd1, dout1);
        check_inst(2, 13'(len2), ovf2, busy2, rdd2, dout2);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            for (int k = 0; k < 3; k++) model_step(k);
            m_cen_prev = cap_en;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_idle();
        cs = 1'b0; w_en = 1'b0; enable = 1'b1; address = 1'b0; din = 8'h00; rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] d, input logic en);
        cs = 1'b1; w_en = 1'b1; enable = en; address = 1'b0; din = d;
        cyc();
        bus_idle();
    endtask

    task automatic host_read(input logic [11:0] a);
        rd = 1'b1; addr = a;
        cyc();
        rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cap_en = 1'b0; upload = 1'b0; addr = '0;
        bus_idle();
        model_reset();
        address = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst.len", 32'(len0), 32'd0);
        check_eq("rst.status", 32'(dout0), 32'h00);
        check_eq("rst.rdata", 32'(rdd0), 32'h00);
        check_all();
        rst_n = 1'b1;
        address = 1'b0;
        cyc();

        // basic capture with high-bit strip and CR->LF
        cap_en = 1'b1;
        cyc();
        cpu_write(8'hC8, 1'b1);
        cpu_write(8'hC9, 1'b1);
        cpu_write(8'h8D, 1'b1);
        check_eq("basic.len", 32'(len0), 32'd3);
        host_read(12'd0); check_eq("basic.rd0", 32'(rdd0), 32'h48);
        host_read(12'd1); check_eq("basic.rd1", 32'(rdd0), 32'h49);
        host_read(12'd2); check_eq("basic.rd2", 32'(rdd0), 32'h0A);
        check_eq("circ.cr_kept", 32'(rdd2), 32'h0D);
        host_read(12'd3); check_eq("basic.rd_past_len", 32'(rdd0), 32'h00);
        cpu_write(8'h87, 1'b1);
        cpu_write(8'hFF, 1'b1);
        cpu_write(8'hC1, 1'b0);
        check_eq("drop.len", 32'(len0), 32'd3);

        // restart capture and overfill the small buffers
        cap_en = 1'b0; cyc();
        cap_en = 1'b1; cyc();
        for (int i = 0; i < 20; i++) cpu_write(8'(8'h41 + i), 1'b1);
        address = 1'b1; cyc();
        check_eq("lin.len", 32'(len1), 32'd16);
        check_eq("lin.ovf", 32'(ovf1), 32'd1);
        check_eq("lin.full_bit", 32'(dout1[5]), 32'd1);
        check_eq("circ.len", 32'(len2), 32'd16);
        check_eq("circ.ovf", 32'(ovf2), 32'd1);
        check_eq("big.len", 32'(len0), 32'd20);
        address = 1'b0;
        host_read(12'd15);
        check_eq("lin.rd15", 32'(rdd1), 32'h50);
        check_eq("circ.rd15", 32'(rdd2), 32'h54);
        host_read(12'd0);
        check_eq("circ.rd0", 32'(rdd2), 32'h45);
        host_read(12'd20);
        check_eq("big.rd_past_len", 32'(rdd0), 32'h00);

        // upload mid-capture drops the concurrent write, then appending resumes
        upload = 1'b1;
        cpu_write(8'hC1, 1'b1);
        check_eq("up.busy", 32'(busy0), 32'd1);
        check_eq("up.len", 32'(len0), 32'd20);
        upload = 1'b0;
        cyc();
        cpu_write(8'h42, 1'b1);
        check_eq("append.len", 32'(len0), 32'd21);
        host_read(12'd20);
        check_eq("append.rd", 32'(rdd0), 32'h42);

        // asynchronous reset mid-capture, capture_en held high
        address = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst.len", 32'(len0), 32'd0);
        check_eq("arst.status", 32'(dout0), 32'h00);
        check_eq("arst.rdata", 32'(rdd0), 32'h00);
        check_eq("arst.ovf", 32'(ovf1), 32'd0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("arst.recapture", 32'(dout0), 32'h80);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cs      = ($urandom % 4) != 0;
            w_en    = ($urandom % 3) != 0;
            enable  = ($urandom % 8) != 0;
            address = ($urandom % 5) == 0;
            din     = ($urandom % 3 != 0) ? 8'(8'h20 + $urandom % 96) : 8'($urandom);
            rd      = $urandom % 2;
            addr    = 12'($urandom_range(0, 24));
            if ($urandom % 50 == 0) cap_en = ~cap_en;
            if ($urandom % 70 == 0) upload = ~upload;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
